frequency_counter_gated: RTL and testbench

Parametrised successor to the frequency counter. It counts rising crossings of a signed ADC sample stream over a programmable gate window. Crossings are qualified by a hysteresis band. Each window's count is presented on an AXI-Stream master with a tready handshake, plus overflow and drop reporting. The block sits between the ADC sample stream and the PS-readable result path.

---
 rtl/frequency_counter_gated.sv | 156 +++++++++++++++
 tb/tb_frequency_counter_gated.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frequency_counter_gated.sv
// Gated frequency counter: counts hysteresis-qualified rising crossings of a signed
// sample stream over a programmable window and streams each window's count out.
module frequency_counter_gated #(
    parameter int DATA_WIDTH  = 14,
    parameter int COUNT_WIDTH = 32,
    parameter int GATE_WIDTH  = 32,
    parameter int HYST        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  S_AXIS_IN_tdata,
    input  logic                   S_AXIS_IN_tvalid,
    input  logic                   enable,
    input  logic [GATE_WIDTH-1:0]  gate_cycles,
    output logic [COUNT_WIDTH-1:0] M_AXIS_OUT_tdata,
    output logic                   M_AXIS_OUT_tvalid,
    input  logic                   M_AXIS_OUT_tready,
    output logic [COUNT_WIDTH-1:0] counter_output,
    output logic                   overflow,
    output logic                   dropped,
    output logic                   o_dbg_state
);

    // Output handshake: a result is transferred in any cycle where tvalid and tready are
    // both high; tvalid then stays high only if a new result loads in that same cycle.

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    // Samples and the hysteresis band are compared in a common signed width wide
    // enough for both, so a large HYST never wraps against narrow samples.
    localparam int CMP_WIDTH = ((DATA_WIDTH > 32) ? DATA_WIDTH : 32) + 1;
    localparam logic signed [CMP_WIDTH-1:0] HYST_POS = CMP_WIDTH'(HYST);
    localparam logic signed [CMP_WIDTH-1:0] HYST_NEG = -HYST_POS;

    state_t                   r_state;
    logic                     r_level;
    logic [GATE_WIDTH-1:0]    r_gate_len;
    logic [GATE_WIDTH-1:0]    r_gate_cnt;
    logic [COUNT_WIDTH-1:0]   r_edge_cnt;
    logic                     r_win_ovf;
    logic [COUNT_WIDTH-1:0]   r_tdata;
    logic                     r_tvalid;
    logic [COUNT_WIDTH-1:0]   r_count_out;
    logic                     r_overflow;
    logic                     r_dropped;

    logic signed [CMP_WIDTH-1:0] w_sample;
    logic                        w_above;
    logic                        w_below;
    logic                        w_edge;
    logic                        w_last;
    logic                        w_sat;
    logic                        w_start;
    logic                        w_hs;
    logic [COUNT_WIDTH-1:0]      w_result;
    logic                        w_result_ovf;

    assign w_sample = CMP_WIDTH'($signed(S_AXIS_IN_tdata));
    assign w_above  = (w_sample > HYST_POS);
    assign w_below  = (w_sample < HYST_NEG);
    assign w_edge   = S_AXIS_IN_tvalid && !r_level && w_above;

    assign w_last   = (r_state == S_COUNT) && (r_gate_cnt == (r_gate_len - GATE_WIDTH'(1)));
    assign w_sat    = &r_edge_cnt;
    assign w_start  = enable && (gate_cycles != '0);
    assign w_hs     = r_tvalid && M_AXIS_OUT_tready;

    // An edge on the closing cycle still belongs to the closing window.
    assign w_result     = (w_edge && !w_sat) ? (r_edge_cnt + COUNT_WIDTH'(1)) : r_edge_cnt;
    assign w_result_ovf = r_win_ovf || (w_edge && w_sat);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= 1'b0;
        end else if (S_AXIS_IN_tvalid) begin
            if (!r_level && w_above) begin
                r_level <= 1'b1;
            end else if (r_level && w_below) begin
                r_level <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_gate_len  <= '0;
            r_gate_cnt  <= '0;
            r_edge_cnt  <= '0;
            r_win_ovf   <= 1'b0;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_count_out <= '0;
            r_overflow  <= 1'b0;
            r_dropped   <= 1'b0;
        end else begin
            r_dropped <= 1'b0;
            if (w_hs) begin
                r_tvalid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state    <= S_COUNT;
                        r_gate_len <= gate_cycles;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_win_ovf  <= 1'b0;
                    end
                end
                S_COUNT: begin
                    if (w_last) begin
                        r_tdata     <= w_result;
                        r_count_out <= w_result;
                        r_overflow  <= w_result_ovf;
                        r_tvalid    <= 1'b1;
                        r_dropped   <= r_tvalid && !M_AXIS_OUT_tready;
                        // Back-to-back windows: relatch the gate with no idle gap.
                        if (w_start) begin
                            r_gate_len <= gate_cycles;
                            r_gate_cnt <= '0;
                            r_edge_cnt <= '0;
                            r_win_ovf  <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (!enable) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gate_cnt <= r_gate_cnt + GATE_WIDTH'(1);
                        if (w_edge) begin
                            if (w_sat) begin
                                r_win_ovf <= 1'b1;
                            end else begin
                                r_edge_cnt <= r_edge_cnt + COUNT_WIDTH'(1);
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign M_AXIS_OUT_tdata  = r_tdata;
    assign M_AXIS_OUT_tvalid = r_tvalid;
    assign counter_output    = r_count_out;
    assign overflow          = r_overflow;
    assign dropped           = r_dropped;
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_frequency_counter_gated.sv
// Directed bench for frequency_counter_gated: expected window results are queued by the
// stimulus and checked by monitors on every output handshake.
module tb_frequency_counter_gated;

    localparam int DW  = 14;
    localparam int CW  = 32;
    localparam int CW4 = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   s_tdata;
    logic            s_tvalid;
    logic            enable;
    logic [31:0]     gate;
    logic [CW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic [CW-1:0]   cnt_out;
    logic            ovf;
    logic            drop;
    logic            dbg_state;

    logic            enable4;
    logic [31:0]     gate4;
    logic            tready4;
    logic [CW4-1:0]  m_tdata4;
    logic            m_tvalid4;
    logic [CW4-1:0]  cnt_out4;
    logic            ovf4;
    logic            drop4;
    logic            dbg_state4;

    logic [CW:0]     exp_q[$];
    logic [CW4:0]    exp4_q[$];

    int checks = 0;
    int errors = 0;
    int drop_cnt = 0;
    int mode = 0;
    int phase = 0;
    int alt_amp = 0;

    int sine_tab[30] = '{0, 160, 313, 453, 572, 667, 732, 766, 766, 732, 667, 572, 453, 313, 160,
                         0, -160, -313, -453, -572, -667, -732, -766, -766, -732, -667, -572,
                         -453, -313, -160};

    always #5 clk = ~clk;

    frequency_counter_gated u_dut (
        .clk(clk), .rst(rst),
        .S_AXIS_IN_tdata(s_tdata), .S_AXIS_IN_tvalid(s_tvalid),
        .enable(enable), .gate_cycles(gate),
        .M_AXIS_OUT_tdata(m_tdata), .M_AXIS_OUT_tvalid(m_tvalid), .M_AXIS_OUT_tready(m_tready),
        .counter_output(cnt_out), .overflow(ovf), .dropped(drop), .o_dbg_state(dbg_state)
    );

    frequency_counter_gated #(.COUNT_WIDTH(CW4)) u_dut4 (
        .clk(clk), .rst(rst),
        .S_AXIS_IN_tdata(s_tdata), .S_AXIS_IN_tvalid(s_tvalid),
        .enable(enable4), .gate_cycles(gate4),
        .M_AXIS_OUT_tdata(m_tdata4), .M_AXIS_OUT_tvalid(m_tvalid4), .M_AXIS_OUT_tready(tready4),
        .counter_output(cnt_out4), .overflow(ovf4), .dropped(drop4), .o_dbg_state(dbg_state4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sample source: 0 zero, 1 sine, 2 alternating +/-alt_amp, 3 masked sine, 4 constant -100.
    always @(posedge clk) begin
        int val;
        #1;
        phase = (phase == 29) ? 0 : phase + 1;
        val = 0;
        s_tvalid = 1'b1;
        case (mode)
            1: val = sine_tab[phase];
            2: val = (phase % 2 == 0) ? alt_amp : -alt_amp;
            3: begin
                val = sine_tab[phase];
                if (phase == 1) s_tvalid = 1'b0;
                if (phase == 20) begin
                    s_tvalid = 1'b0;
                    val = 700;
                end
            end
            4: val = -100;
            default: val = 0;
        endcase
        s_tdata = DW'(val);
    end

    always @(negedge clk) begin
        logic [CW:0] e;
        if (!rst && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0d expected none", m_tdata);
            end else begin
                e = exp_q.pop_front();
                check("result", {ovf, m_tdata}, e);
                check("counter_output", cnt_out, e[CW-1:0]);
            end
        end
        if (!rst && drop) drop_cnt++;
    end

    always @(negedge clk) begin
        logic [CW4:0] e;
        if (!rst && m_tvalid4 && tready4) begin
            if (exp4_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result4: got %0d expected none", m_tdata4);
            end else begin
                e = exp4_q.pop_front();
                check("result4", {ovf4, m_tdata4}, e);
                check("counter_output4", cnt_out4, e[CW4-1:0]);
            end
        end
    end

    task automatic check_reset_state();
        check("rst_tdata", m_tdata, 0);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_counter_output", cnt_out, 0);
        check("rst_overflow", ovf, 0);
        check("rst_dropped", drop, 0);
        check("rst_state", dbg_state, 0);
    endtask

    task automatic precondition(input int new_mode, input int amp);
        mode = 4;
        tick(5);
        alt_amp = amp;
        mode = new_mode;
        tick(40);
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        gate = 0;
        m_tready = 1'b1;
        enable4 = 1'b0;
        gate4 = 0;
        tready4 = 1'b1;
        s_tdata = '0;
        s_tvalid = 1'b1;
        tick(3);
        check_reset_state();
        rst = 1'b0;

        // Continuous sine, three full windows then abort mid-window.
        precondition(1, 0);
        gate = 300;
        enable = 1'b1;
        repeat (3) exp_q.push_back({1'b0, 32'd10});
        tick(3 * 300 + 150);
        enable = 1'b0;
        tick(5);
        check("abort_tvalid", m_tvalid, 0);
        check("abort_counter_output", cnt_out, 10);
        check("abort_state", dbg_state, 0);

        // Zero-length gate never leaves IDLE.
        gate = 0;
        enable = 1'b1;
        tick(50);
        check("gate0_state", dbg_state, 0);
        check("gate0_tvalid", m_tvalid, 0);
        enable = 1'b0;

        // Alternation inside the band, then just outside it.
        precondition(2, 10);
        gate = 100;
        enable = 1'b1;
        exp_q.push_back({1'b0, 32'd0});
        tick(150);
        enable = 1'b0;
        precondition(2, 20);
        enable = 1'b1;
        exp_q.push_back({1'b0, 32'd50});
        tick(150);
        enable = 1'b0;

        // Narrow counter saturates; gate change takes effect at the next window.
        precondition(2, 100);
        gate4 = 64;
        enable4 = 1'b1;
        exp4_q.push_back({1'b1, 4'd15});
        exp4_q.push_back({1'b0, 4'd8});
        tick(10);
        gate4 = 16;
        tick(79);
        enable4 = 1'b0;
        tick(5);

        // Backpressure: second result overwrites the first.
        precondition(1, 0);
        m_tready = 1'b0;
        gate = 300;
        enable = 1'b1;
        exp_q.push_back({1'b0, 32'd10});
        tick(650);
        check("held_tvalid", m_tvalid, 1);
        check("held_tdata", m_tdata, 10);
        tick(50);
        m_tready = 1'b1;
        tick(20);
        check("drained_tvalid", m_tvalid, 0);
        check("drop_count", drop_cnt, 1);
        tick(30);
        enable = 1'b0;
        tick(5);

        // Invalid samples are ignored, then reset mid-window.
        precondition(3, 0);
        gate = 300;
        enable = 1'b1;
        repeat (2) exp_q.push_back({1'b0, 32'd10});
        tick(750);
        rst = 1'b1;
        enable = 1'b0;
        tick(1);
        check_reset_state();
        rst = 1'b0;
        tick(5);

        for (int i = 0; i < 200 && (exp_q.size() != 0 || exp4_q.size() != 0); i++) tick(1);
        while (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL missing_result: got none expected %0d", exp_q.pop_front());
        end
        while (exp4_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL missing_result4: got none expected %0d", exp4_q.pop_front());
        end
        check("final_drop_count", drop_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
